// File: rtl/dct_sample_packer.sv
// dct_sample_packer
// Packs a serial stream of signed samples into BLK_LEN-sample vectors for the
// 4-point DCT. Two ping-pong banks let the write side fill one vector while the
// read side presents the other, so one sample per clock is sustained.
// blk_o[0] is the oldest sample of the vector.

module dct_sample_packer #(
    parameter int DATA_W  = 8,
    parameter int BLK_LEN = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    input  logic [DATA_W-1:0]              smp_i,
    input  logic                           smp_valid_i,
    input  logic                           smp_last_i,
    output logic                           smp_ready_o,
    output logic [BLK_LEN-1:0][DATA_W-1:0] blk_o,
    output logic [2:0]                     blk_cnt_o,
    output logic                           blk_last_o,
    output logic                           blk_valid_o,
    input  logic                           blk_ready_i
);

    localparam int                WCNT_W   = (BLK_LEN > 1) ? $clog2(BLK_LEN) : 1;
    localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(BLK_LEN - 1);

    // Per-bank storage: samples, occupancy, real-sample count and stream-end flag.
    logic [DATA_W-1:0] bank_data [2][BLK_LEN];
    logic [1:0]        bank_full;
    logic [2:0]        bank_cnt  [2];
    logic [1:0]        bank_last;

    logic              wr_bank;
    logic              rd_bank;
    logic [WCNT_W-1:0] wr_cnt;

    logic              accept;
    logic              close_blk;
    logic              pop;

    // Handshake decode; everything here depends on registered state except the
    // qualifying valid/last/ready inputs, so smp_ready_o has no input path.
    assign smp_ready_o = !bank_full[wr_bank];
    assign accept      = smp_valid_i && smp_ready_o;
    assign close_blk   = accept && (smp_last_i || (wr_cnt == WCNT_MAX));
    assign blk_valid_o = bank_full[rd_bank];
    assign pop         = blk_valid_o && blk_ready_i;
    assign blk_cnt_o   = bank_cnt[rd_bank];
    assign blk_last_o  = bank_last[rd_bank];

    // Present the read bank; when empty this is stale data the consumer ignores.
    always_comb begin
        // NOTE: every output of a combinational block gets a value on every path,
        // otherwise synthesis infers a latch to hold the old value.
        blk_o = '0;
        for (int i = 0; i < BLK_LEN; i++) begin
            blk_o[i] = bank_data[rd_bank][i];
        end
    end

    // Write slot counter and bank pointers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        // NOTE: state updates use non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (!rst_n_i) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_cnt  <= '0;
        end else begin
            if (accept) begin
                wr_cnt <= close_blk ? '0 : wr_cnt + WCNT_W'(1);
            end
            if (close_blk) begin
                wr_bank <= ~wr_bank;
            end
            if (pop) begin
                rd_bank <= ~rd_bank;
            end
        end
    end

    // Bank bookkeeping: a close fills the write bank, a pop frees the read bank.
    // The two never target the same bank in one cycle because a full bank
    // blocks acceptance, so both may take effect together.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bank_full <= '0;
            bank_last <= '0;
            for (int b = 0; b < 2; b++) begin
                bank_cnt[b] <= '0;
            end
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (pop && (rd_bank == 1'(b))) begin
                    bank_full[b] <= 1'b0;
                end
                if (close_blk && (wr_bank == 1'(b))) begin
                    bank_full[b] <= 1'b1;
                    bank_cnt[b]  <= 3'(wr_cnt) + 3'd1;
                    bank_last[b] <= smp_last_i;
                end
            end
        end
    end

    // Sample storage: write the accepted sample and zero-pad unused slots on close.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        // NOTE: the sample banks are reset on purpose: blk_o must read zero out of
        // reset, which costs a reset net on each storage flop.
        if (!rst_n_i) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < BLK_LEN; i++) begin
                    bank_data[b][i] <= '0;
                end
            end
        end else if (accept) begin
            for (int i = 0; i < BLK_LEN; i++) begin
                if (i == int'(wr_cnt)) begin
                    bank_data[wr_bank][i] <= smp_i;
                end else if (close_blk && (i > int'(wr_cnt))) begin
                    bank_data[wr_bank][i] <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_dct_sample_packer.sv
// tb_dct_sample_packer
// Scoreboarded bench: every accepted sample feeds a small packing model that
// pushes expected vectors; a negedge monitor pops and compares on each handshake.

module tb_dct_sample_packer;

    localparam int DATA_W   = 8;
    localparam int BLK_LEN  = 4;
    localparam int MAX_WAIT = 40;

    typedef struct {
        logic [BLK_LEN-1:0][DATA_W-1:0] data;
        logic [2:0]                     cnt;
        logic                           last;
    } vec_t;

    logic                           clk;
    logic                           clk_en;
    logic                           rst_n;
    logic [DATA_W-1:0]              smp;
    logic                           smp_valid;
    logic                           smp_last;
    logic                           smp_ready;
    logic [BLK_LEN-1:0][DATA_W-1:0] blk;
    logic [2:0]                     blk_cnt;
    logic                           blk_last;
    logic                           blk_valid;
    logic                           blk_ready;

    int checks;
    int errors;
    int pop_count;

    vec_t              exp_q[$];
    logic [DATA_W-1:0] cur_data [BLK_LEN];
    int                cur_n;

    dct_sample_packer #(.DATA_W(DATA_W), .BLK_LEN(BLK_LEN)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .smp_i       (smp),
        .smp_valid_i (smp_valid),
        .smp_last_i  (smp_last),
        .smp_ready_o (smp_ready),
        .blk_o       (blk),
        .blk_cnt_o   (blk_cnt),
        .blk_last_o  (blk_last),
        .blk_valid_o (blk_valid),
        .blk_ready_i (blk_ready)
    );

    // Gateable clock so reset can be pulsed with no edges present.
    initial clk = 1'b0;
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    // Scoreboard monitor: a handshake seen at the negedge completes at the next posedge.
    always @(negedge clk) begin
        if (rst_n && blk_valid && blk_ready) begin
            pop_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_vector got data=%h cnt=%0d last=%0b", blk, blk_cnt, blk_last);
            end else begin
                vec_t e;
                e = exp_q.pop_front();
                if (blk !== e.data || blk_cnt !== e.cnt || blk_last !== e.last) begin
                    errors++;
                    $display("FAIL vector_out got data=%h cnt=%0d last=%0b expected data=%h cnt=%0d last=%0b",
                             blk, blk_cnt, blk_last, e.data, e.cnt, e.last);
                end
            end
        end
    end

    // Packing model: called once per accepted sample.
    task automatic model_accept(input logic [DATA_W-1:0] d, input logic last);
        vec_t v;
        cur_data[cur_n] = d;
        cur_n++;
        if (cur_n == BLK_LEN || last) begin
            v.data = '0;
            for (int i = 0; i < cur_n; i++) v.data[i] = cur_data[i];
            v.cnt  = 3'(cur_n);
            v.last = last;
            exp_q.push_back(v);
            cur_n = 0;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        cur_n = 0;
    endtask

    // Present one sample (called just after a posedge) until accepted; returns stall cycles.
    task automatic drive_sample(input logic [DATA_W-1:0] d, input logic last, output int waits);
        int n;
        n         = 0;
        smp       = d;
        smp_valid = 1'b1;
        smp_last  = last;
        @(negedge clk);
        while (!smp_ready && n < MAX_WAIT) begin
            n++;
            @(negedge clk);
        end
        if (!smp_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout sample=%h not accepted after %0d cycles", d, n);
        end else begin
            model_accept(d, last);
        end
        @(posedge clk);
        #1;
        waits = n;
    endtask

    task automatic idle();
        smp_valid = 1'b0;
        smp_last  = 1'b0;
        smp       = '0;
    endtask

    // Wait (bounded) for all expected vectors to be consumed, then confirm no extra one.
    task automatic drain(input string name);
        int n;
        n = 0;
        blk_ready = 1'b1;
        while (exp_q.size() != 0 && n < MAX_WAIT) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain_timeout %0d vectors still pending", name, exp_q.size());
        end
        @(negedge clk);
        checks++;
        if (blk_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_extra_vector blk_valid=%0b expected 0", name, blk_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int w;
        #1;
        checks++;
        if (blk_valid !== 1'b0 || blk !== '0 || blk_cnt !== 3'd0 || blk_last !== 1'b0 || smp_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_initial valid=%0b data=%h cnt=%0d last=%0b ready=%0b expected 0/0/0/0/1",
                     blk_valid, blk, blk_cnt, blk_last, smp_ready);
        end
        #6 rst_n = 1'b1;
        @(posedge clk);
        #1;
        // Fill one vector and hold it so the outputs are non-zero before reset.
        blk_ready = 1'b0;
        for (int i = 0; i < BLK_LEN; i++) drive_sample(8'(8'h31 + i), 1'b0, w);
        idle();
        @(negedge clk);
        checks++;
        if (blk_valid !== 1'b1 || blk_cnt !== 3'd4) begin
            errors++;
            $display("FAIL reset_prefill valid=%0b cnt=%0d expected 1/4", blk_valid, blk_cnt);
        end
        clk_en = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (blk_valid !== 1'b0 || blk !== '0 || blk_cnt !== 3'd0 || blk_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_async valid=%0b data=%h cnt=%0d last=%0b expected all 0",
                     blk_valid, blk, blk_cnt, blk_last);
        end
        #2 rst_n = 1'b1;
        #1 clk_en = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (smp_ready !== 1'b1 || blk_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release ready=%0b valid=%0b expected 1/0", smp_ready, blk_valid);
        end
    endtask

    task automatic test_stream();
        int vals[8] = '{1, -2, 3, -4, 5, -6, 7, -8};
        int w;
        int p0;
        p0        = pop_count;
        blk_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive_sample(8'(vals[i]), 1'b0, w);
            checks++;
            if (w != 0) begin
                errors++;
                $display("FAIL stream_ready sample %0d stalled %0d cycles expected 0", i, w);
            end
        end
        idle();
        drain("stream");
        checks++;
        if (pop_count - p0 != 2) begin
            errors++;
            $display("FAIL stream_vectors got %0d vectors expected 2", pop_count - p0);
        end
    endtask

    task automatic test_last();
        int w;
        blk_ready = 1'b1;
        drive_sample(8'd10, 1'b0, w);
        drive_sample(8'd20, 1'b0, w);
        drive_sample(8'd30, 1'b1, w);
        // Next vector must start at slot 0.
        for (int i = 0; i < BLK_LEN; i++) drive_sample(8'(40 + i), 1'b0, w);
        idle();
        drain("last");
    endtask

    task automatic test_backpressure();
        logic [DATA_W-1:0]              s [12];
        logic [BLK_LEN-1:0][DATA_W-1:0] head;
        int w;
        for (int i = 0; i < 12; i++) s[i] = 8'(8'hA0 + i * 5);
        for (int i = 0; i < BLK_LEN; i++) head[i] = s[i];
        blk_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive_sample(s[i], 1'b0, w);
            checks++;
            if (w != 0) begin
                errors++;
                $display("FAIL bp_fill sample %0d stalled %0d cycles expected 0", i, w);
            end
        end
        // Both banks full: sample 8 must be refused and the head vector held.
        smp       = s[8];
        smp_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (smp_ready !== 1'b0 || blk_valid !== 1'b1 || blk !== head || blk_cnt !== 3'd4) begin
                errors++;
                $display("FAIL bp_hold cycle %0d ready=%0b valid=%0b data=%h cnt=%0d expected 0/1/%h/4",
                         c, smp_ready, blk_valid, blk, blk_cnt, head);
            end
            @(posedge clk);
            #1;
        end
        blk_ready = 1'b1;
        drive_sample(s[8], 1'b0, w);
        checks++;
        if (w != 1) begin
            errors++;
            $display("FAIL bp_resume stalled %0d cycles after pop expected 1", w);
        end
        for (int i = 9; i < 12; i++) drive_sample(s[i], 1'b0, w);
        idle();
        drain("bp");
    endtask

    task automatic test_simultaneous();
        logic [BLK_LEN-1:0][DATA_W-1:0] bank_b;
        int w;
        for (int i = 0; i < BLK_LEN; i++) bank_b[i] = 8'(8'h70 + i);
        blk_ready = 1'b0;
        for (int i = 0; i < BLK_LEN; i++) drive_sample(8'(8'h60 + i), 1'b0, w);
        for (int i = 0; i < BLK_LEN - 1; i++) drive_sample(bank_b[i], 1'b0, w);
        // Close bank B on the same edge that pops bank A.
        blk_ready = 1'b1;
        drive_sample(bank_b[BLK_LEN-1], 1'b0, w);
        blk_ready = 1'b0;
        idle();
        @(negedge clk);
        checks++;
        if (blk_valid !== 1'b1 || blk !== bank_b || blk_cnt !== 3'd4 || smp_ready !== 1'b1) begin
            errors++;
            $display("FAIL simul_close_pop valid=%0b data=%h cnt=%0d ready=%0b expected 1/%h/4/1",
                     blk_valid, blk, blk_cnt, smp_ready, bank_b);
        end
        @(posedge clk);
        #1;
        drain("simul");
    endtask

    task automatic test_reset_mid();
        int w;
        int p0;
        blk_ready = 1'b1;
        drive_sample(8'h01, 1'b0, w);
        drive_sample(8'h02, 1'b0, w);
        idle();
        rst_n = 1'b0;
        model_reset();
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        p0 = pop_count;
        for (int i = 0; i < BLK_LEN; i++) drive_sample(8'd7, 1'b0, w);
        idle();
        drain("rst_mid");
        checks++;
        if (pop_count - p0 != 1) begin
            errors++;
            $display("FAIL rst_mid_vectors got %0d vectors expected 1", pop_count - p0);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        pop_count = 0;
        cur_n     = 0;
        clk_en    = 1'b1;
        rst_n     = 1'b0;
        smp       = '0;
        smp_valid = 1'b0;
        smp_last  = 1'b0;
        blk_ready = 1'b0;

        test_reset();
        test_stream();
        test_last();
        test_backpressure();
        test_simultaneous();
        test_reset_mid();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
